// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one data-memory channel among
// the per-thread LSUs of a compute core. Each granted request is a single beat
// (read or write). It is held on the memory handshake until completion. The
// response is then relayed back to the requester until that requester drops
// its valid.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to build a watchdog. A WAITING
// state that sees no memory ready for TIMEOUT_CYCLES cycles completes with
// zero data and sets the sticky timeout_error flag. Without the macro no
// counter is built, timeout_error is tied low and WAITING waits indefinitely.
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   consumer_req_valid/write   per-requester request strobe and direction
//   consumer_req_address/data  per-requester address and write data
//   consumer_resp_ready/data   per-requester response strobe and read data
//   mem_read_*                 memory read handshake (valid/address out, ready/data in)
//   mem_write_*                memory write handshake (valid/address/data out, ready in)
//   busy                       high whenever the FSM is not IDLE
//   grant_id                   current or most recent granted requester
//   timeout_error              sticky watchdog flag
module mem_arbiter #(
    parameter int unsigned NUM_CONSUMERS  = 4,
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic [NUM_CONSUMERS-1:0]         consumer_req_valid,
    input  logic [NUM_CONSUMERS-1:0]         consumer_req_write,
    input  logic [ADDR_BITS-1:0]             consumer_req_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]             consumer_req_data    [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0]         consumer_resp_ready,
    output logic [DATA_BITS-1:0]             consumer_resp_data   [NUM_CONSUMERS],

    output logic                             mem_read_valid,
    output logic [ADDR_BITS-1:0]             mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [DATA_BITS-1:0]             mem_read_data,

    output logic                             mem_write_valid,
    output logic [ADDR_BITS-1:0]             mem_write_address,
    output logic [DATA_BITS-1:0]             mem_write_data,
    input  logic                             mem_write_ready,

    output logic                             busy,
    output logic [$clog2(NUM_CONSUMERS)-1:0] grant_id,
    output logic                             timeout_error
);

    localparam int unsigned ID_W = $clog2(NUM_CONSUMERS);

    // Elaboration-time parameter sanity checks
    if (NUM_CONSUMERS < 2) begin : g_bad_consumers
        $error("mem_arbiter: NUM_CONSUMERS must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        READ_WAITING  = 2'd1,
        WRITE_WAITING = 2'd2,
        RELAYING      = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        grant_d;
    logic                   rd_valid_d, wr_valid_d;
    logic [ADDR_BITS-1:0]   rd_addr_d, wr_addr_d;
    logic [DATA_BITS-1:0]   wr_data_d;
    logic [NUM_CONSUMERS-1:0] resp_ready_d;
    logic [DATA_BITS-1:0]   resp_data_d [NUM_CONSUMERS];
    logic                   busy_d;

    logic                   scan_found;
    logic [ID_W-1:0]        scan_pick;
    int unsigned            scan_idx;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   timeout_hit;
    logic                   timeout_err_d;

    // Fires on the last permitted WAITING cycle without a memory ready
    assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive WAITING cycles; clears whenever WAITING is left
    always_comb begin : timer_next
        timer_d = '0;
        if ((state_q == READ_WAITING || state_q == WRITE_WAITING) && (state_d == state_q)) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end
`else
    assign timeout_error = 1'b0;
`endif

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping
    always_comb begin : rr_scan
        scan_found = 1'b0;
        scan_pick  = '0;
        scan_idx   = 0;
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
            scan_idx = 32'(rr_ptr_q) + k;
            if (scan_idx >= NUM_CONSUMERS) begin
                scan_idx = scan_idx - NUM_CONSUMERS;
            end
            if (!scan_found && consumer_req_valid[ID_W'(scan_idx)]) begin
                scan_found = 1'b1;
                scan_pick  = ID_W'(scan_idx);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin : fsm_next
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_id;
        rd_valid_d   = mem_read_valid;
        wr_valid_d   = mem_write_valid;
        rd_addr_d    = mem_read_address;
        wr_addr_d    = mem_write_address;
        wr_data_d    = mem_write_data;
        resp_ready_d = consumer_resp_ready;
        resp_data_d  = consumer_resp_data;
`ifdef MEM_ARB_TIMEOUT_EN
        timeout_err_d = timeout_error;
`endif

        case (state_q)
            IDLE: begin
                if (scan_found) begin
                    grant_d = scan_pick;
                    if (consumer_req_write[scan_pick]) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = consumer_req_address[scan_pick];
                        wr_data_d  = consumer_req_data[scan_pick];
                        state_d    = WRITE_WAITING;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = consumer_req_address[scan_pick];
                        state_d    = READ_WAITING;
                    end
                end
            end

            READ_WAITING: begin
                if (mem_read_ready) begin
                    rd_valid_d             = 1'b0;
                    resp_data_d[grant_id]  = mem_read_data;
                    resp_ready_d[grant_id] = 1'b1;
                    state_d                = RELAYING;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    rd_valid_d             = 1'b0;
                    resp_data_d[grant_id]  = '0;
                    resp_ready_d[grant_id] = 1'b1;
                    timeout_err_d          = 1'b1;
                    state_d                = RELAYING;
                end
`endif
            end

            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    wr_valid_d             = 1'b0;
                    resp_data_d[grant_id]  = '0;
                    resp_ready_d[grant_id] = 1'b1;
                    state_d                = RELAYING;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    wr_valid_d             = 1'b0;
                    resp_data_d[grant_id]  = '0;
                    resp_ready_d[grant_id] = 1'b1;
                    timeout_err_d          = 1'b1;
                    state_d                = RELAYING;
                end
`endif
            end

            RELAYING: begin
                // Hold the response until the requester withdraws its request
                if (!consumer_req_valid[grant_id]) begin
                    resp_ready_d[grant_id] = 1'b0;
                    rr_ptr_d = (grant_id == ID_W'(NUM_CONSUMERS - 1)) ? '0 : grant_id + ID_W'(1);
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin : regs
        if (reset) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            grant_id            <= '0;
            mem_read_valid      <= 1'b0;
            mem_write_valid     <= 1'b0;
            mem_read_address    <= '0;
            mem_write_address   <= '0;
            mem_write_data      <= '0;
            consumer_resp_ready <= '0;
            for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
                consumer_resp_data[i] <= '0;
            end
            busy                <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            timer_q             <= '0;
            timeout_error       <= 1'b0;
`endif
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            grant_id            <= grant_d;
            mem_read_valid      <= rd_valid_d;
            mem_write_valid     <= wr_valid_d;
            mem_read_address    <= rd_addr_d;
            mem_write_address   <= wr_addr_d;
            mem_write_data      <= wr_data_d;
            consumer_resp_ready <= resp_ready_d;
            for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
                consumer_resp_data[i] <= resp_data_d[i];
            end
            busy                <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
            timer_q             <= timer_d;
            timeout_error       <= timeout_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (4 consumers, 8-bit address/data).
// Build with MEM_ARB_TIMEOUT_EN defined to exercise the watchdog with TIMEOUT_CYCLES=8.
module tb_mem_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 8;

    logic          clk;
    logic          reset;
    logic [N-1:0]  consumer_req_valid;
    logic [N-1:0]  consumer_req_write;
    logic [AW-1:0] consumer_req_address [N];
    logic [DW-1:0] consumer_req_data    [N];
    logic [N-1:0]  consumer_resp_ready;
    logic [DW-1:0] consumer_resp_data   [N];
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic          mem_write_valid;
    logic [AW-1:0] mem_write_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_ready;
    logic          busy;
    logic [1:0]    grant_id;
    logic          timeout_error;

    int checks = 0;
    int errors = 0;

    // Memory model controls
    int            mem_lat = 1;
    bit            mem_en  = 1'b1;
    logic [DW-1:0] mem_rdata_cfg = '0;
    int            mem_cnt = 0;

    mem_arbiter #(
        .NUM_CONSUMERS (N),
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .consumer_req_valid  (consumer_req_valid),
        .consumer_req_write  (consumer_req_write),
        .consumer_req_address(consumer_req_address),
        .consumer_req_data   (consumer_req_data),
        .consumer_resp_ready (consumer_resp_ready),
        .consumer_resp_data  (consumer_resp_data),
        .mem_read_valid      (mem_read_valid),
        .mem_read_address    (mem_read_address),
        .mem_read_ready      (mem_read_ready),
        .mem_read_data       (mem_read_data),
        .mem_write_valid     (mem_write_valid),
        .mem_write_address   (mem_write_address),
        .mem_write_data      (mem_write_data),
        .mem_write_ready     (mem_write_ready),
        .busy                (busy),
        .grant_id            (grant_id),
        .timeout_error       (timeout_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: raises ready once a request has been visible for mem_lat falling edges
    initial begin
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_data   = '0;
    end
    always @(negedge clk) begin
        if (mem_read_valid || mem_write_valid) mem_cnt = mem_cnt + 1;
        else                                   mem_cnt = 0;
        mem_read_ready  = mem_read_valid  && mem_en && (mem_cnt >= mem_lat);
        mem_write_ready = mem_write_valid && mem_en && (mem_cnt >= mem_lat);
        mem_read_data   = mem_read_ready ? mem_rdata_cfg : 8'h00;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        consumer_req_valid = '0;
        consumer_req_write = '0;
        mem_en  = 1'b1;
        mem_lat = 1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits (bounded) for resp_ready[id]; reports falling edges waited and memory activity
    task automatic wait_resp(input int id, output int cyc, output bit saw_rd, output bit saw_wr);
        cyc = 0; saw_rd = 1'b0; saw_wr = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            saw_rd |= mem_read_valid;
            saw_wr |= mem_write_valid;
        end while (!consumer_resp_ready[id] && cyc < 100);
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(mem_read_valid || mem_write_valid) && cyc < 100);
    endtask

    initial begin
        int cyc;
        int hi;
        bit saw_rd, saw_wr;
        logic [DW-1:0] got;

        reset = 1'b1;
        consumer_req_valid = '0;
        consumer_req_write = '0;
        for (int i = 0; i < N; i++) begin
            consumer_req_address[i] = '0;
            consumer_req_data[i]    = '0;
        end

        // Reset state
        #3;
        check("rst_busy",       32'(busy), 32'd0);
        check("rst_rd_valid",   32'(mem_read_valid), 32'd0);
        check("rst_wr_valid",   32'(mem_write_valid), 32'd0);
        check("rst_grant",      32'(grant_id), 32'd0);
        check("rst_resp_ready", 32'(consumer_resp_ready), 32'd0);
        check("rst_timeout",    32'(timeout_error), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single read: consumer 2, address 0x10, data 0xA5, ready 3 cycles after valid
        @(negedge clk);
        mem_lat = 3;
        mem_rdata_cfg = 8'hA5;
        consumer_req_address[2] = 8'h10;
        consumer_req_write[2]   = 1'b0;
        consumer_req_valid[2]   = 1'b1;
        @(negedge clk);
        check("rd_valid",   32'(mem_read_valid), 32'd1);
        check("rd_addr",    32'(mem_read_address), 32'h10);
        check("rd_grant",   32'(grant_id), 32'd2);
        check("rd_busy",    32'(busy), 32'd1);
        check("rd_no_wr",   32'(mem_write_valid), 32'd0);
        wait_resp(2, cyc, saw_rd, saw_wr);
        check("rd_latency", 32'(cyc), 32'd3);
        check("rd_data",    32'(consumer_resp_data[2]), 32'hA5);
        check("rd_ready_mask", 32'(consumer_resp_ready), 32'b0100);
        check("rd_valid_drop", 32'(mem_read_valid), 32'd0);
        consumer_req_valid[2] = 1'b0;
        @(negedge clk);
        check("rd_relay_exit", 32'(consumer_resp_ready), 32'd0);
        check("rd_idle",       32'(busy), 32'd0);
        check("rd_grant_hold", 32'(grant_id), 32'd2);

        // Read by consumer 0 so its response register holds nonzero data
        mem_lat = 1;
        mem_rdata_cfg = 8'h77;
        consumer_req_address[0] = 8'h30;
        consumer_req_valid[0]   = 1'b1;
        wait_resp(0, cyc, saw_rd, saw_wr);
        check("rd0_latency", 32'(cyc), 32'd2);
        check("rd0_data",    32'(consumer_resp_data[0]), 32'h77);
        consumer_req_valid[0] = 1'b0;
        @(negedge clk);

        // Single write: consumer 0 writes 0x3C to 0x20
        mem_lat = 2;
        consumer_req_address[0] = 8'h20;
        consumer_req_data[0]    = 8'h3C;
        consumer_req_write[0]   = 1'b1;
        consumer_req_valid[0]   = 1'b1;
        @(negedge clk);
        check("wr_valid", 32'(mem_write_valid), 32'd1);
        check("wr_addr",  32'(mem_write_address), 32'h20);
        check("wr_data",  32'(mem_write_data), 32'h3C);
        check("wr_grant", 32'(grant_id), 32'd0);
        check("wr_no_rd_grant", 32'(mem_read_valid), 32'd0);
        wait_resp(0, cyc, saw_rd, saw_wr);
        check("wr_latency",    32'(cyc), 32'd2);
        check("wr_no_rd",      32'(saw_rd), 32'd0);
        check("wr_resp_data",  32'(consumer_resp_data[0]), 32'h00);
        check("wr_ready_mask", 32'(consumer_resp_ready), 32'b0001);
        consumer_req_valid[0] = 1'b0;
        consumer_req_write[0] = 1'b0;
        @(negedge clk);
        check("wr_idle", 32'(busy), 32'd0);

        // Asynchronous reset while stuck in READ_WAITING
        mem_en = 1'b0;
        consumer_req_address[3] = 8'h44;
        consumer_req_valid[3]   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ar_rd_valid", 32'(mem_read_valid), 32'd1);
        check("ar_grant",    32'(grant_id), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("ar_rd_valid_clr", 32'(mem_read_valid), 32'd0);
        check("ar_busy_clr",     32'(busy), 32'd0);
        check("ar_grant_clr",    32'(grant_id), 32'd0);
        check("ar_addr_clr",     32'(mem_read_address), 32'd0);
        check("ar_data_clr",     32'(consumer_resp_data[2]), 32'd0);
        consumer_req_valid = '0;
        @(negedge clk);
        reset  = 1'b0;
        mem_en = 1'b1;

        // Consumer 1 drops valid while WAITING: completes, ready pulses once
        @(negedge clk);
        mem_lat = 3;
        mem_rdata_cfg = 8'h5E;
        consumer_req_address[1] = 8'h11;
        consumer_req_valid[1]   = 1'b1;
        @(negedge clk);
        check("drop_grant", 32'(grant_id), 32'd1);
        check("drop_valid", 32'(mem_read_valid), 32'd1);
        consumer_req_valid[1] = 1'b0;
        hi = 0;
        got = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (consumer_resp_ready[1]) begin
                hi++;
                got = consumer_resp_data[1];
            end
        end
        check("drop_pulse_len", 32'(hi), 32'd1);
        check("drop_data",      32'(got), 32'h5E);
        check("drop_idle",      32'(busy), 32'd0);

        // All four request continuously from reset: grants 0,1,2,3,0 with one IDLE cycle between
        apply_reset();
        mem_lat = 1;
        mem_rdata_cfg = 8'hC3;
        for (int i = 0; i < N; i++) begin
            consumer_req_address[i] = 8'(8'h80 + i);
            consumer_req_write[i]   = 1'b0;
        end
        consumer_req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            int gid;
            wait_grant(cyc);
            check("rr_gap",   32'(cyc), 32'd1);
            check("rr_grant", 32'(grant_id), 32'(g % 4));
            check("rr_addr",  32'(mem_read_address), 32'(8'h80 + (g % 4)));
            gid = g % 4;
            wait_resp(gid, cyc, saw_rd, saw_wr);
            check("rr_data", 32'(consumer_resp_data[gid]), 32'hC3);
            consumer_req_valid[gid] = 1'b0;
            @(negedge clk);
            check("rr_idle_cycle", 32'(busy), 32'd0);
            check("rr_ready_clr",  32'(consumer_resp_ready), 32'd0);
            if (g < 4) consumer_req_valid[gid] = 1'b1;
        end
        consumer_req_valid = '0;
        @(negedge clk);
        check("rr_end_idle", 32'(busy), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: read never acknowledged, then next requester is served
        apply_reset();
        mem_en = 1'b0;
        mem_rdata_cfg = 8'h9D;
        consumer_req_address[1] = 8'h21;
        consumer_req_address[2] = 8'h22;
        consumer_req_valid = 4'b0110;
        wait_resp(1, cyc, saw_rd, saw_wr);
        check("to_latency",   32'(cyc), 32'd9);
        check("to_flag",      32'(timeout_error), 32'd1);
        check("to_resp_data", 32'(consumer_resp_data[1]), 32'd0);
        check("to_rd_drop",   32'(mem_read_valid), 32'd0);
        consumer_req_valid[1] = 1'b0;
        mem_en = 1'b1;
        wait_grant(cyc);
        check("to_next_gap",   32'(cyc), 32'd2);
        check("to_next_grant", 32'(grant_id), 32'd2);
        wait_resp(2, cyc, saw_rd, saw_wr);
        check("to_next_data",  32'(consumer_resp_data[2]), 32'h9D);
        check("to_sticky",     32'(timeout_error), 32'd1);
        consumer_req_valid = '0;
        @(negedge clk);
`else
        // No watchdog: an unacknowledged read waits indefinitely
        apply_reset();
        mem_en = 1'b0;
        consumer_req_address[1] = 8'h21;
        consumer_req_valid[1]   = 1'b1;
        repeat (30) @(negedge clk);
        check("nw_rd_valid",   32'(mem_read_valid), 32'd1);
        check("nw_resp_ready", 32'(consumer_resp_ready), 32'd0);
        check("nw_timeout",    32'(timeout_error), 32'd0);
        check("nw_busy",       32'(busy), 32'd1);
        mem_en = 1'b1;
        wait_resp(1, cyc, saw_rd, saw_wr);
        check("nw_ready_mask", 32'(consumer_resp_ready), 32'b0010);
        consumer_req_valid = '0;
        @(negedge clk);
        check("nw_idle", 32'(busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
